fifo_nibble_packer: RTL and testbench

Downstream consumer of the synchronous 4-bit FIFO `fifo`. It drains the FIFO read port, pulling one nibble per cycle whenever data is available. It assembles `LANES` nibbles into one wide word and presents each word on a valid/ready output port to the next stage. A `flush` request emits a partially filled word, zero-padded, so that trailing data is never stranded in the FIFO path.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/lane_insert.sv | 24 ++
 rtl/fifo_nibble_packer.sv | 155 +++++++++++++++
 tb/tb_fifo_nibble_packer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the nibble FIFO and its downstream packer.
package fifo_pkg;

  // Packer control state: normal collection or draining a partial word.
  typedef enum logic {
    COLLECT = 1'b0,
    FLUSH   = 1'b1
  } state_t;

  // Data width of the upstream FIFO.
  localparam int FIFO_DW = 4;

  // Width of the accepted-word counter.
  localparam int WCNT_W = 16;

endpackage

// File: rtl/lane_insert.sv
// Places one nibble into lane position k of an otherwise zero word.
// k is the arrival order inside the word; LSB_FIRST picks the lane direction.
// A k outside 0..LANES-1 yields an all-zero word.
module lane_insert #(
  parameter int DIN_W     = 4,
  parameter int LANES     = 2,
  parameter int LSB_FIRST = 1,
  parameter int KW        = 2
) (
  input  logic [DIN_W-1:0]       nib,
  input  logic [KW-1:0]          k,
  output logic [DIN_W*LANES-1:0] word
);

  // Route the nibble to the lane that matches its arrival order.
  always_comb begin
    word = '0;
    for (int i = 0; i < LANES; i++) begin
      word[i*DIN_W +: DIN_W] =
        (k == KW'((LSB_FIRST != 0) ? i : (LANES - 1 - i))) ? nib : {DIN_W{1'b0}};
    end
  end

endmodule

// File: rtl/fifo_nibble_packer.sv
// Drains a 1-cycle-latency FIFO read port, packs LANES nibbles per word and
// presents words on a valid/ready port. A flush emits a zero-padded partial word.
module fifo_nibble_packer
  import fifo_pkg::*;
#(
  parameter int DIN_W     = FIFO_DW,
  parameter int LANES     = 2,
  parameter int LSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DIN_W-1:0]       fifo_dout,
  input  logic                   flush,
  output logic [DIN_W*LANES-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_partial,
  output logic [WCNT_W-1:0]      word_cnt
);

  localparam int CW = $clog2(LANES + 1);
  localparam int OW = DIN_W * LANES;

  state_t          state_r, state_nx_s;
  logic [CW-1:0]   cnt_r, cnt_nx_s;
  logic            inflight_r;
  logic [OW-1:0]   asm_r, asm_nx_s;
  logic [OW-1:0]   ins_word_s, merged_s;
  logic            out_free_s;
  logic            emit_s, emit_partial_s;
  logic [OW-1:0]   emit_word_s;

  // The returning nibble always lands at position cnt of the word being built.
  lane_insert #(
    .DIN_W    (DIN_W),
    .LANES    (LANES),
    .LSB_FIRST(LSB_FIRST),
    .KW       (CW)
  ) u_lane_insert (
    .nib (fifo_dout),
    .k   (cnt_r),
    .word(ins_word_s)
  );

  assign merged_s   = asm_r | ins_word_s;
  assign out_free_s = !out_valid || out_ready;

  // Capture, word hand-off and flush sequencing.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    asm_nx_s       = asm_r;
    emit_s         = 1'b0;
    emit_word_s    = asm_r;
    emit_partial_s = 1'b0;

    if (inflight_r) begin
      // Nibble returning from the FIFO this cycle.
      if ((cnt_r == CW'(LANES - 1)) && out_free_s) begin
        emit_s      = 1'b1;
        emit_word_s = merged_s;
        cnt_nx_s    = '0;
        asm_nx_s    = '0;
      end else begin
        cnt_nx_s = cnt_r + CW'(1);
        asm_nx_s = merged_s;
      end
    end else if (cnt_r == CW'(LANES)) begin
      // A complete word waiting for the output register.
      if (out_free_s) begin
        emit_s      = 1'b1;
        emit_word_s = asm_r;
        cnt_nx_s    = '0;
        asm_nx_s    = '0;
      end else begin
        cnt_nx_s = cnt_r;
      end
    end else if ((cnt_r != '0) && ((state_r == FLUSH) || flush)) begin
      // Partial word requested out; unfilled lanes are already zero.
      if (out_free_s) begin
        emit_s         = 1'b1;
        emit_word_s    = asm_r;
        emit_partial_s = 1'b1;
        cnt_nx_s       = '0;
        asm_nx_s       = '0;
      end else begin
        cnt_nx_s = cnt_r;
      end
    end else begin
      cnt_nx_s = cnt_r;
    end

    case (state_r)
      COLLECT: begin
        // An immediate partial emission already drained everything.
        if (flush && ((cnt_r != '0) || inflight_r) && !(emit_s && emit_partial_s)) begin
          state_nx_s = FLUSH;
        end else begin
          state_nx_s = COLLECT;
        end
      end
      FLUSH: begin
        if (emit_s || (!inflight_r && (cnt_r == '0))) begin
          state_nx_s = COLLECT;
        end else begin
          state_nx_s = FLUSH;
        end
      end
      default: state_nx_s = COLLECT;
    endcase
  end

  // Read whenever the post-cycle occupancy leaves room for one more nibble.
  always_comb begin
    fifo_rd_en = !rst && !fifo_empty && (state_r == COLLECT) && (cnt_nx_s < CW'(LANES));
  end

  // State, assembly and output registers; a read pending across reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= COLLECT;
      cnt_r       <= '0;
      inflight_r  <= 1'b0;
      asm_r       <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_partial <= 1'b0;
      word_cnt    <= '0;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      inflight_r <= fifo_rd_en;
      asm_r      <= asm_nx_s;
      if (emit_s) begin
        out_data    <= emit_word_s;
        out_valid   <= 1'b1;
        out_partial <= emit_partial_s;
      end else if (out_ready) begin
        out_valid   <= 1'b0;
        out_partial <= 1'b0;
      end else begin
        out_valid   <= out_valid;
        out_partial <= out_partial;
      end
      if (out_valid && out_ready) begin
        word_cnt <= word_cnt + WCNT_W'(1);
      end else begin
        word_cnt <= word_cnt;
      end
    end
  end

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Scoreboard bench for fifo_nibble_packer (LANES=2), LSB-first and MSB-first
// instances, each fed by a small behavioural 1-cycle-latency FIFO.
module tb_fifo_nibble_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, out_ready;

  logic       empty_a, rd_a, valid_a, partial_a;
  logic [3:0] dout_a;
  logic [7:0] data_a;
  logic [15:0] wcnt_a;

  logic       empty_b, rd_b, valid_b, partial_b;
  logic [3:0] dout_b;
  logic [7:0] data_b;
  logic [15:0] wcnt_b;

  fifo_nibble_packer #(.DIN_W(4), .LANES(2), .LSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .fifo_empty(empty_a), .fifo_rd_en(rd_a), .fifo_dout(dout_a),
    .flush(flush), .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready),
    .out_partial(partial_a), .word_cnt(wcnt_a)
  );

  fifo_nibble_packer #(.DIN_W(4), .LANES(2), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .fifo_empty(empty_b), .fifo_rd_en(rd_b), .fifo_dout(dout_b),
    .flush(flush), .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready),
    .out_partial(partial_b), .word_cnt(wcnt_b)
  );

  // Behavioural FIFOs: write pointer driven by stimulus, read pointer by the DUT.
  logic [3:0] mem_a [0:63];
  logic [3:0] mem_b [0:63];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
  assign empty_a = (wp_a == rp_a);
  assign empty_b = (wp_b == rp_b);

  always @(posedge clk) begin
    if (rst) begin
      rp_a <= wp_a;
    end else if (rd_a) begin
      dout_a <= mem_a[rp_a[5:0]];
      rp_a   <= rp_a + 1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      rp_b <= wp_b;
    end else if (rd_b) begin
      dout_b <= mem_b[rp_b[5:0]];
      rp_b   <= rp_b + 1;
    end
  end

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_a [$];
  logic [8:0] exp_b [$];

  // Monitor: pops the scoreboard on every handshake, watches read gating.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && valid_a && out_ready) begin
      checks++;
      if (exp_a.size() == 0) begin
        failures++;
        $display("FAIL sb_lsb unexpected word actual=%h", {partial_a, data_a});
      end else begin
        e = exp_a.pop_front();
        if ({partial_a, data_a} !== e) begin
          failures++;
          $display("FAIL sb_lsb word actual=%h expected=%h", {partial_a, data_a}, e);
        end
      end
    end
    if (!rst && valid_b && out_ready) begin
      checks++;
      if (exp_b.size() == 0) begin
        failures++;
        $display("FAIL sb_msb unexpected word actual=%h", {partial_b, data_b});
      end else begin
        e = exp_b.pop_front();
        if ({partial_b, data_b} !== e) begin
          failures++;
          $display("FAIL sb_msb word actual=%h expected=%h", {partial_b, data_b}, e);
        end
      end
    end
    checks++;
    if ((rd_a && empty_a) || (rd_b && empty_b)) begin
      failures++;
      $display("FAIL rd_while_empty actual=1 expected=0");
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [3:0] v);
    mem_a[wp_a[5:0]] = v;
    wp_a++;
  endtask

  task automatic push_b(input logic [3:0] v);
    mem_b[wp_b[5:0]] = v;
    wp_b++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [19:0] rdv, vv, vvb;
  int rd_count, bad, vcount;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_data", 32'(data_a), 32'h0);
    chk("reset_valid", 32'(valid_a), 32'h0);
    chk("reset_partial", 32'(partial_a), 32'h0);
    chk("reset_wcnt", 32'(wcnt_a), 32'h0);
    chk("reset_rd_en", 32'(rd_a), 32'h0);

    // Basic order, both lane directions.
    step();
    exp_a.push_back({1'b0, 8'hA3});
    exp_b.push_back({1'b0, 8'h3A});
    push_a(4'h3); push_a(4'hA);
    push_b(4'h3); push_b(4'hA);
    rdv = '0; vv = '0; vvb = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rdv[i] = rd_a;
      vv[i]  = valid_a;
      vvb[i] = valid_b;
    end
    chk("basic_rd_pattern", 32'(rdv), 32'h003);
    chk("basic_valid_lat", 32'(vv), 32'h008);
    chk("basic_valid_lat_msb", 32'(vvb), 32'h008);
    chk("basic_wcnt", 32'(wcnt_a), 32'h1);

    // Streaming 8 nibbles.
    do_reset();
    exp_a.push_back({1'b0, 8'h21});
    exp_a.push_back({1'b0, 8'h43});
    exp_a.push_back({1'b0, 8'h65});
    exp_a.push_back({1'b0, 8'h87});
    for (int i = 1; i <= 8; i++) push_a(4'(i));
    rdv = '0; vv = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdv[i] = rd_a;
      vv[i]  = valid_a;
    end
    chk("stream_rd_run", 32'(rdv), 32'h000FF);
    chk("stream_valid_cadence", 32'(vv), 32'h002A8);
    chk("stream_wcnt", 32'(wcnt_a), 32'h4);

    // Backpressure: 6 nibbles with the consumer stalled.
    do_reset();
    out_ready = 1'b0;
    exp_a.push_back({1'b0, 8'h21});
    exp_a.push_back({1'b0, 8'h43});
    exp_a.push_back({1'b0, 8'h65});
    for (int i = 1; i <= 6; i++) push_a(4'(i));
    rd_count = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rd_a) rd_count++;
      if (valid_a && (data_a !== 8'h21)) bad++;
    end
    chk("bp_reads", 32'(rd_count), 32'd4);
    chk("bp_fifo_left", 32'(wp_a - rp_a), 32'd2);
    chk("bp_valid_held", 32'(valid_a), 32'h1);
    chk("bp_data_held", 32'(data_a), 32'h21);
    chk("bp_data_stable", 32'(bad), 32'd0);
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge clk);
    chk("bp_wcnt", 32'(wcnt_a), 32'h3);

    // Flush of one captured nibble.
    do_reset();
    push_a(4'h5);
    step(); step(); step();
    exp_a.push_back({1'b1, 8'h05});
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid_n1", 32'(valid_a), 32'h1);
    chk("flush_partial", 32'(partial_a), 32'h1);
    // Flush with nothing buffered.
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (valid_a) vcount++;
    end
    chk("flush_empty_noword", 32'(vcount), 32'd0);
    // Flush while the nibble is still in flight.
    step();
    push_a(4'h7);
    step();
    exp_a.push_back({1'b1, 8'h07});
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_inflight_not_n1", 32'(valid_a), 32'h0);
    step();
    @(negedge clk);
    chk("flush_inflight_valid_n2", 32'(valid_a), 32'h1);
    chk("flush_inflight_partial", 32'(partial_a), 32'h1);
    chk("flush_wcnt", 32'(wcnt_a), 32'h1);

    // Empty gating over 20 cycles.
    step();
    rd_count = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_a) rd_count++;
    end
    chk("empty_no_reads", 32'(rd_count), 32'd0);

    // Reset after one nibble captured.
    step();
    push_a(4'h9);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_data", 32'(data_a), 32'h0);
    chk("rst_mid_valid", 32'(valid_a), 32'h0);
    chk("rst_mid_partial", 32'(partial_a), 32'h0);
    chk("rst_mid_wcnt", 32'(wcnt_a), 32'h0);
    chk("rst_mid_rd_en", 32'(rd_a), 32'h0);
    step();
    exp_a.push_back({1'b0, 8'hDC});
    push_a(4'hC); push_a(4'hD);
    for (int i = 0; i < 8; i++) @(negedge clk);
    chk("rst_mid_wcnt_after", 32'(wcnt_a), 32'h1);

    chk("sb_lsb_drained", 32'(exp_a.size()), 32'd0);
    chk("sb_msb_drained", 32'(exp_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
